// File: rtl/xgmii_rx_deframer.sv
// rtl/xgmii_rx_deframer.sv - 64-bit XGMII receive deframer to an AXI-Stream master without backpressure
// Define XGMII_RX_FCS_CHECK_EN to add a CRC-32 FCS check to the frame status.
module xgmii_rx_deframer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  rx_good_frame,
  output logic                  rx_bad_frame
);
  localparam int NW = $clog2(CTRL_WIDTH + 1);
  localparam logic [7:0]  CH_START  = 8'hFB;
  localparam logic [7:0]  CH_TERM   = 8'hFD;
  localparam logic [15:0] MIN_FRAME = 16'd64;

  typedef enum logic {IDLE, PAYLOAD} state_t;
  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d, tdata_q, tdata_d;
  logic [CTRL_WIDTH-1:0] skid_keep_q, skid_keep_d, tkeep_q, tkeep_d, word_keep;
  logic                  skid_vld_q, skid_vld_d, err_q, err_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                  good_q, good_d, bad_q, bad_d;
  logic [15:0]           cnt_q, cnt_d, cnt_sum;
  logic [16:0]           cnt_wide;
  logic                  is_start, s_lane0, term_found, ctrl_err, frame_bad, end_bad;
  logic                  frame_start, accept;
  logic [NW-1:0]         n_bytes;

  // n_bytes is the number of payload lanes in this word: the lane of the first /T/, else all.
  always_comb begin
    s_lane0  = xgmii_rxc[0] && (xgmii_rxd[7:0] == CH_START);
    is_start = s_lane0 && (xgmii_rxc[CTRL_WIDTH-1:1] == '0) &&
               (xgmii_rxd[DATA_WIDTH-1 -: 8] == 8'hD5);
    for (int i = 1; i < CTRL_WIDTH - 1; i++)
      if (xgmii_rxd[8*i +: 8] != 8'h55) is_start = 1'b0;
    term_found = 1'b0;
    n_bytes    = NW'(CTRL_WIDTH);
    for (int i = CTRL_WIDTH - 1; i >= 0; i--)
      if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == CH_TERM)) begin
        term_found = 1'b1;
        n_bytes    = NW'(i);
      end
    ctrl_err  = 1'b0;
    word_keep = '0;
    for (int i = 0; i < CTRL_WIDTH; i++)
      if (NW'(i) < n_bytes) begin
        word_keep[i] = 1'b1;
        ctrl_err     = ctrl_err | xgmii_rxc[i];
      end
  end

  assign cnt_wide = {1'b0, cnt_q} + 17'(n_bytes);
  assign cnt_sum  = cnt_wide[16] ? 16'hFFFF : cnt_wide[15:0];

`ifdef XGMII_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  logic [31:0] crc_q, crc_d, crc_word;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // The register is LSB-first; the residue constant is written MSB-first.
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

  always_comb begin
    crc_word = crc_q;
    for (int i = 0; i < CTRL_WIDTH; i++)
      if (word_keep[i]) crc_word = crc32_byte(crc_word, xgmii_rxd[8*i +: 8]);
    crc_d = frame_start ? CRC_INIT : (accept ? crc_word : crc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign frame_bad = err_q || (cnt_q < MIN_FRAME) || (rev32(crc_q) != CRC_RESIDUE);
`else
  assign frame_bad = err_q || (cnt_q < MIN_FRAME);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_start) state_d = PAYLOAD;
      PAYLOAD: if (!s_lane0 && term_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A word with /T/ in lane k>=1 stays in the skid and is flushed as tlast from IDLE.
  always_comb begin
    tdata_d     = '0;
    tkeep_d     = '0;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    end_bad     = 1'b0;
    skid_data_d = skid_data_q;
    skid_keep_d = skid_keep_q;
    skid_vld_d  = skid_vld_q;
    frame_start = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (skid_vld_q) begin
          tvalid_d = 1'b1;
          tdata_d  = skid_data_q;
          tkeep_d  = skid_keep_q;
          tlast_d  = 1'b1;
          tuser_d  = frame_bad;
          good_d   = !frame_bad;
          bad_d    = frame_bad;
        end
        skid_vld_d  = 1'b0;
        frame_start = is_start;
      end
      PAYLOAD: begin
        if (s_lane0 || (term_found && (n_bytes == '0))) begin
          end_bad = s_lane0 || frame_bad;
          if (skid_vld_q) begin
            tvalid_d = 1'b1;
            tdata_d  = skid_data_q;
            tkeep_d  = skid_keep_q;
            tlast_d  = 1'b1;
            tuser_d  = end_bad;
          end
          good_d      = !end_bad;
          bad_d       = end_bad;
          skid_vld_d  = 1'b0;
          frame_start = s_lane0;
        end else begin
          if (skid_vld_q) begin
            tvalid_d = 1'b1;
            tdata_d  = skid_data_q;
            tkeep_d  = skid_keep_q;
          end
          skid_data_d = xgmii_rxd;
          skid_keep_d = word_keep;
          skid_vld_d  = 1'b1;
          accept      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (frame_start) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      err_d = err_q | ctrl_err;
      cnt_d = cnt_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data_q <= '0;
      skid_keep_q <= '0;
      skid_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      skid_data_q <= skid_data_d;
      skid_keep_q <= skid_keep_d;
      skid_vld_q  <= skid_vld_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign rx_good_frame = good_q;
  assign rx_bad_frame  = bad_q;
endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// tb/tb_xgmii_rx_deframer.sv - frame-level expectation model vs. xgmii_rx_deframer under random traffic
module tb_xgmii_rx_deframer;
  localparam int NCYC = 2500;
  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] xgmii_rxd, m_axis_tdata;
  logic [7:0]  xgmii_rxc, m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, rx_good_frame, rx_bad_frame;

  xgmii_rx_deframer dut (
    .clk(clk), .rst(rst), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame)
  );

  always #5 clk = ~clk;

  // Index e: input word sampled at rising edge e; expected output visible just after edge e.
  logic [63:0] in_d [NCYC];
  logic [7:0]  in_c [NCYC];
  logic        in_r [NCYC];
  logic [63:0] ex_d [NCYC];
  logic [7:0]  ex_k [NCYC];
  logic        ex_v [NCYC], ex_l [NCYC], ex_u [NCYC], ex_g [NCYC], ex_b [NCYC];
  logic [7:0]  act_k [NCYC];
  logic        act_v [NCYC], act_l [NCYC], act_u [NCYC], act_g [NCYC], act_b [NCYC];
  logic [7:0]  fb [256];
  int checks = 0;
  int errors = 0;
  int pos;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string nm, input int e, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual 0x%0h required 0x%0h", nm, e, act, exp);
    end
  endtask

  // kind 0: terminated by /T/; kind 1: cut by the next start word; kind 2: cut by reset.
  task automatic add_frame(input int len, input int err_p, input bit flip, input int kind,
                           input int cut, input int gap);
    int s, nw, k, j;
    logic [31:0] c;
    logic [7:0] bv;
    bit bad;
    for (int p = 0; p < len; p++) fb[p] = 8'($urandom_range(0, 255));
    if (kind == 0 && len >= 4) begin
      c = 32'hFFFFFFFF;
      for (int p = 0; p < len - 4; p++) c = crc_step(c, fb[p]);
      c = ~c;
      for (int b = 0; b < 4; b++) fb[len-4+b] = c[8*b +: 8];
      if (flip) fb[len-1] = fb[len-1] ^ 8'h01;
    end
    s  = pos;
    nw = (len + 7) / 8;
    k  = len % 8;
    in_d[s] = START_D;
    in_c[s] = 8'h01;
    for (int w = 1; w <= nw + 1; w++) begin
      in_d[s+w] = IDLE_D;
      in_c[s+w] = 8'hFF;
    end
    for (int p = 0; p < len; p++) begin
      j  = s + 1 + p / 8;
      bv = fb[p];
      if (p == err_p) bv = ($urandom_range(0, 1) == 1) ? 8'hFE : 8'h07;
      in_d[j][8*(p%8) +: 8] = bv;
      in_c[j][p%8] = (p == err_p);
    end
    if (kind == 0) begin
      if (k == 0) in_d[s+nw+1][7:0] = 8'hFD;
      else begin
        in_d[s+nw][8*k +: 8] = 8'hFD;
        in_c[s+nw][k] = 1'b1;
      end
    end
    bad = (err_p >= 0) || (len < 64) || (kind == 1);
`ifdef XGMII_RX_FCS_CHECK_EN
    if (flip) bad = 1'b1;
`endif
    if (kind == 2) in_r[s+1+cut] = 1'b1;
    for (int w = 1; w <= nw; w++) begin
      j = s + w + 1;
      if (kind == 2 && w >= cut) break;
      ex_v[j] = 1'b1;
      ex_d[j] = in_d[s+w];
      ex_k[j] = (w == nw && k != 0) ? 8'((1 << k) - 1) : 8'hFF;
      if (w == nw && kind != 2) begin
        ex_l[j] = 1'b1;
        ex_u[j] = bad;
        ex_g[j] = !bad;
        ex_b[j] = bad;
      end
    end
    if (len == 0) ex_b[s+1] = 1'b1;
    pos = s + nw + 1 + ((kind == 0 && k == 0) ? 1 : 0) + gap;
  endtask

  initial begin
    int sA, sB, sC, sD, sE, sF, sG, sH, sZ, sK, n_cyc, cnt, len, kind, nw;
    logic [63:0] mask;
    for (int e = 0; e < NCYC; e++) begin
      in_d[e] = IDLE_D; in_c[e] = 8'hFF; in_r[e] = 1'b0;
      ex_d[e] = '0; ex_k[e] = '0; ex_v[e] = 0; ex_l[e] = 0; ex_u[e] = 0; ex_g[e] = 0; ex_b[e] = 0;
    end
    for (int e = 0; e < 3; e++) in_r[e] = 1'b1;
    pos = 4;
    sA = pos; add_frame(64, -1, 0, 0, 0, 2);
    sB = pos; add_frame(67, -1, 0, 0, 0, 1);
    sC = pos; add_frame(72, 26, 0, 0, 0, 1);
    sD = pos; add_frame(40, -1, 0, 0, 0, 1);
    sE = pos; add_frame(24, -1, 0, 1, 0, 0);
    sF = pos; add_frame(80, -1, 0, 0, 0, 1);
    sG = pos; add_frame(48, -1, 0, 2, 3, 2);
    sH = pos; add_frame(64, -1, 0, 0, 0, 1);
    sZ = pos; add_frame(0, -1, 0, 0, 0, 1);
    sK = pos; add_frame(100, -1, 1, 0, 0, 1);
    while (pos < NCYC - 60) begin
      kind = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
      if (kind == 0) begin
        len = $urandom_range(0, 130);
        add_frame(len, ($urandom_range(0, 5) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1,
                  0, 0, 0, $urandom_range(0, 2));
      end else begin
        nw = $urandom_range(2, 6);
        if (kind == 1) begin
          add_frame(8 * nw, -1, 0, 1, 0, 0);
          add_frame(64 + $urandom_range(0, 40), -1, 0, 0, 0, $urandom_range(0, 2));
        end else add_frame(8 * nw, -1, 0, 2, $urandom_range(1, nw), $urandom_range(1, 2));
      end
    end
    n_cyc = pos + 4;

    for (int e = 0; e < n_cyc; e++) begin
      rst = in_r[e]; xgmii_rxd = in_d[e]; xgmii_rxc = in_c[e];
      @(posedge clk);
      #1;
      act_v[e] = m_axis_tvalid; act_k[e] = m_axis_tkeep; act_l[e] = m_axis_tlast;
      act_u[e] = m_axis_tuser;  act_g[e] = rx_good_frame; act_b[e] = rx_bad_frame;
      chk("tvalid", e, m_axis_tvalid, ex_v[e]);
      chk("tkeep", e, m_axis_tkeep, ex_k[e]);
      chk("tlast", e, m_axis_tlast, ex_l[e]);
      chk("tuser", e, m_axis_tuser, ex_u[e]);
      chk("good", e, rx_good_frame, ex_g[e]);
      chk("bad", e, rx_bad_frame, ex_b[e]);
      if (ex_v[e]) begin
        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{ex_k[e][b]}};
        chk("tdata", e, m_axis_tdata & mask, ex_d[e] & mask);
      end
    end

    cnt = 0;
    for (int e = sA; e < sA + 12; e++) cnt += int'(act_v[e]);
    chk("A_beats", sA, cnt, 8);
    chk("A_latency_before", sA + 1, act_v[sA+1], 0);
    chk("A_latency_first", sA + 2, act_v[sA+2], 1);
    chk("A_last_keep", sA + 9, act_k[sA+9], 8'hFF);
    chk("A_last_flag", sA + 9, {act_l[sA+9], act_u[sA+9], act_g[sA+9], act_b[sA+9]}, 4'b1010);
    cnt = 0;
    for (int e = sB; e < sB + 13; e++) cnt += int'(act_v[e]);
    chk("B_beats", sB, cnt, 9);
    chk("B_last_keep", sB + 10, act_k[sB+10], 8'h07);
    chk("B_last_flag", sB + 10, {act_l[sB+10], act_u[sB+10], act_g[sB+10]}, 3'b101);
    chk("C_err_frame", sC + 10, {act_l[sC+10], act_u[sC+10], act_b[sC+10]}, 3'b111);
    chk("D_runt", sD + 6, {act_l[sD+6], act_u[sD+6], act_b[sD+6]}, 3'b111);
    chk("E_cut_by_start", sE + 4, {act_l[sE+4], act_u[sE+4], act_b[sE+4]}, 3'b111);
    chk("F_after_restart", sF + 11, {act_l[sF+11], act_g[sF+11]}, 2'b11);
    chk("G_reset_quiet", sG + 4, {act_v[sG+4], act_l[sG+4]}, 2'b00);
    cnt = 0;
    for (int e = sG; e < sH; e++) cnt += int'(act_l[e]) + int'(act_g[e]) + int'(act_b[e]);
    chk("G_no_status", sG, cnt, 0);
    chk("H_good_after_reset", sH + 9, {act_l[sH+9], act_g[sH+9]}, 2'b11);
    chk("Z_zero_payload", sZ + 1, {act_v[sZ+1], act_b[sZ+1]}, 2'b01);
`ifdef XGMII_RX_FCS_CHECK_EN
    chk("K_fcs_flip", sK + 14, {act_l[sK+14], act_u[sK+14], act_b[sK+14]}, 3'b111);
`else
    chk("K_fcs_flip", sK + 14, {act_l[sK+14], act_u[sK+14], act_g[sK+14]}, 3'b101);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
